// File: rtl/seq_gen_tx.sv
// seq_gen_tx: repeating serial pattern transmitter.
//
// On a start request in IDLE, captures pattern/len/rep and shifts the low
// len bits of the pattern out MSB-first, one bit per cycle. This is repeated
// rep+1 times, with a one-cycle gap between repetitions. The transfer ends
// with a one-cycle done pulse. All outputs are registered.
//
// Ports:
//   clk     - sole clock, rising edge
//   reset   - asynchronous active-low reset
//   start   - transmit request, sampled only in IDLE
//   pattern - bits to send; bit len-1 goes first
//   len     - pattern length in bits (values above WIDTH are clamped)
//   rep     - additional repetitions (total transmissions = rep+1)
//   dout    - serial data bit
//   valid   - dout carries a pattern bit
//   busy    - high in every state except IDLE
//   done    - one-cycle completion pulse
//   led     - state indicator: IDLE 001, SEND 010, GAP 100, DONE 111
module seq_gen_tx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       len,
    input  logic [3:0]       rep,
    output logic             dout,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [2:0]       led
);

    // Wide enough to hold WIDTH itself, so a full-length pattern fits.
    localparam int unsigned LW = $clog2(WIDTH + 1);
    localparam logic [LW-1:0] One = LW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap,
        StDone
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] pat_q;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    idx_q;
    logic [3:0]       rep_q;

    logic [LW-1:0]    len_clamp;
    logic [LW-1:0]    idx_next;
    logic [WIDTH-1:0] sh_in;
    logic [WIDTH-1:0] sh_first;
    logic [WIDTH-1:0] sh_next;
    logic             bit_first_in;
    logic             bit_first_q;
    logic             bit_next;

    always_comb begin
        len_clamp = '0;
        if (int'(len) > int'(WIDTH)) begin
            len_clamp = LW'(WIDTH);
        end else begin
            len_clamp = LW'(len);
        end
        idx_next = idx_q - One;
        // Shifts keep the bit selects free of index-width mismatches.
        sh_in        = pattern >> (len_clamp - One);
        sh_first     = pat_q >> (len_q - One);
        sh_next      = pat_q >> idx_next;
        bit_first_in = sh_in[0];
        bit_first_q  = sh_first[0];
        bit_next     = sh_next[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= StIdle;
            pat_q <= '0;
            len_q <= '0;
            idx_q <= '0;
            rep_q <= '0;
            dout  <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            led   <= 3'b001;
        end else begin
            unique case (state)
                StIdle: begin
                    dout  <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    led   <= 3'b001;
                    if (start) begin
                        pat_q <= pattern;
                        len_q <= len_clamp;
                        rep_q <= rep;
                        busy  <= 1'b1;
                        if (len_clamp == '0) begin
                            // Empty pattern: nothing to send, just signal completion.
                            state <= StDone;
                            done  <= 1'b1;
                            led   <= 3'b111;
                        end else begin
                            state <= StSend;
                            idx_q <= len_clamp - One;
                            dout  <= bit_first_in;
                            valid <= 1'b1;
                            led   <= 3'b010;
                        end
                    end
                end
                StSend: begin
                    if (idx_q == '0) begin
                        dout  <= 1'b0;
                        valid <= 1'b0;
                        if (rep_q != 4'd0) begin
                            state <= StGap;
                            led   <= 3'b100;
                        end else begin
                            state <= StDone;
                            done  <= 1'b1;
                            led   <= 3'b111;
                        end
                    end else begin
                        idx_q <= idx_next;
                        dout  <= bit_next;
                    end
                end
                StGap: begin
                    rep_q <= rep_q - 4'd1;
                    state <= StSend;
                    idx_q <= len_q - One;
                    dout  <= bit_first_q;
                    valid <= 1'b1;
                    led   <= 3'b010;
                end
                StDone: begin
                    state <= StIdle;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    led   <= 3'b001;
                end
                default: begin
                    state <= StIdle;
                    dout  <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    led   <= 3'b001;
                end
            endcase
        end
    end

endmodule
